actor_sync_trigger: RTL and testbench
=====================================

Name: actor_sync_trigger

Overview:
- Parametrised next-generation trigger; one instance sits beside each HLS actor in a dataflow network.
- Repeatedly launches the actor through an ap_start/ap_done-style handshake and decodes the actor's return code.
- Backs off into a timed sleep when the actor makes no progress.
- Runs a network-wide two-phase synchronisation so every trigger agrees on global quiescence before signalling completion.
- Adds a MODE parameter, a configurable sleep timer and a saturating execution counter.

Parameters:
- MODE, 0, trigger role: 0 = ACTOR_TRIGGER, 1 = INPUT_TRIGGER, 2 = OUTPUT_TRIGGER. In modes 1 and 2 the sleep timer is disabled.
- SLEEP_CYCLES, 16, cycles spent in SLEEP before retrying. Legal range 1..65535.
- COUNT_WIDTH, 32, width of exec_count.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous active-high reset
- ap_start  in  1  request to run the actor until network quiescence
- ap_done  out  1  one-cycle pulse when the run completes
- ap_idle  out  1  high while in IDLE_STATE
- actor_start  out  1  one-cycle launch pulse to the actor
- actor_done  in  1  actor invocation finished; actor_return is valid
- actor_return  in  32  0=IDLE, 1=WAIT, 2=TEST, 3=EXECUTED
- sleep  out  1  high in SLEEP
- sync_wait  out  1  high in SYNC_WAIT
- sync_exec  out  1  high in SYNC_EXEC
- all_sleep  in  1  AND of every trigger's sleep output
- all_sync  in  1  AND over all triggers of (sync_wait OR sync_exec)
- all_sync_wait  in  1  AND of every trigger's sync_wait output
- exec_count  out  COUNT_WIDTH  number of EXECUTED returns in the current run

Behaviour:
- Reset: ap_rst asynchronous and active-high; ap_clk is the only clock. Asserting ap_rst at any time, including mid-invocation, forces:
  - state = IDLE_STATE
  - sleep timer = 0, exec_count = 0
  - ap_done = actor_start = sleep = sync_wait = sync_exec = 0
  - ap_idle = 1
- State encoding, 3 bits: IDLE_STATE=0, LAUNCH=1, CHECK=2, SLEEP=3, SYNC_LAUNCH=4, SYNC_CHECK=5, SYNC_WAIT=6, SYNC_EXEC=7. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE_STATE:
  - ap_start=1 -> LAUNCH; exec_count cleared in the same edge.
  - ap_start=0 -> stay.
- LAUNCH: actor_start=1 for exactly this cycle -> CHECK unconditionally.
- CHECK: waits for actor_done; actor_done is ignored in every other state. On actor_done:
  - EXECUTED -> LAUNCH; exec_count+1.
  - TEST -> LAUNCH.
  - IDLE or WAIT -> SLEEP; timer loaded with SLEEP_CYCLES-1.
  - Any return value >3 is treated as WAIT.
- SLEEP (sleep=1):
  - all_sleep=1 -> SYNC_LAUNCH. This has priority over timer expiry in the same cycle.
  - Otherwise, if MODE=0 and timer==0 -> LAUNCH.
  - Otherwise decrement the timer.
  - In MODE 1/2, stay until all_sleep.
- SYNC_LAUNCH: actor_start=1 for one cycle -> SYNC_CHECK.
- SYNC_CHECK: on actor_done:
  - EXECUTED -> SYNC_EXEC; exec_count+1.
  - Any other value -> SYNC_WAIT.
- SYNC_WAIT (sync_wait=1), when all_sync=1:
  - all_sync_wait=1 -> IDLE_STATE, with ap_done=1 during the first IDLE_STATE cycle.
  - all_sync_wait=0 -> LAUNCH.
- SYNC_EXEC (sync_exec=1): when all_sync=1 -> LAUNCH.
- exec_count saturates at all-ones and does not wrap; it holds its value after ap_done until the next ap_start.
- Latency:
  - ap_start to first actor_start: 1 cycle.
  - actor_done(EXECUTED) to the next actor_start: 1 cycle.
  - all_sync to ap_done: 1 cycle.
- ap_start asserted in any state other than IDLE_STATE is ignored.
- ap_done and ap_start coincident in IDLE_STATE: ap_done still pulses, and the new run starts on the same edge.

Test Plan:
- Reset mid-CHECK: assert ap_rst asynchronously with no clock edge -> state 0, ap_idle=1, exec_count=0 immediately.
- Basic run, MODE=0: ap_start, actor returns EXECUTED x3 then WAIT; all_sleep=0 -> actor_start pulses 4 times; exec_count=3; sleep high for 16 cycles, then relaunch.
- Sync quiescence: in SLEEP, drive all_sleep=1 -> SYNC_LAUNCH next cycle; actor returns WAIT -> sync_wait=1; drive all_sync=all_sync_wait=1 -> ap_done pulse 1 cycle later, ap_idle=1.
- Sync with progress elsewhere: in SYNC_WAIT, drive all_sync=1 and all_sync_wait=0 -> LAUNCH; no ap_done. Actor returning EXECUTED in SYNC_CHECK -> sync_exec=1, exec_count increments.
- MODE=1 with SLEEP_CYCLES=4: sleep held for more than 100 cycles without relaunch until all_sleep=1. Timer expiry coincident with all_sleep in MODE=0 -> SYNC_LAUNCH.
- Saturation, COUNT_WIDTH=4: 20 EXECUTED returns -> exec_count=15. Return value 7 -> treated as WAIT, enters SLEEP.

Source files
------------

// File: rtl/actor_sync_trigger.sv
// Dataflow actor trigger: launches the actor, sleeps on no progress,
// and joins a network-wide two-phase sync before reporting done.
module actor_sync_trigger #(
    parameter int MODE         = 0,
    parameter int SLEEP_CYCLES = 16,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic                   actor_start,
    input  logic                   actor_done,
    input  logic [31:0]            actor_return,
    output logic                   sleep,
    output logic                   sync_wait,
    output logic                   sync_exec,
    input  logic                   all_sleep,
    input  logic                   all_sync,
    input  logic                   all_sync_wait,
    output logic [COUNT_WIDTH-1:0] exec_count
);

    typedef enum logic [2:0] {
        IDLE_STATE  = 3'd0,
        LAUNCH      = 3'd1,
        CHECK       = 3'd2,
        SLEEP       = 3'd3,
        SYNC_LAUNCH = 3'd4,
        SYNC_CHECK  = 3'd5,
        SYNC_WAIT   = 3'd6,
        SYNC_EXEC   = 3'd7
    } state_t;

    localparam logic [15:0] SLEEP_LOAD = 16'(SLEEP_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [31:0] RET_TEST = 32'd2;
    localparam logic [31:0] RET_EXEC = 32'd3;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            timer;
    logic [15:0]            timer_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   done_next;

    // Saturate instead of wrapping so a long run never reports a small count.
    assign count_inc = (exec_count == COUNT_MAX) ? exec_count
                                                 : exec_count + 1'b1;

    always_comb begin
        state_next = state;
        timer_next = timer;
        count_next = exec_count;
        done_next  = 1'b0;
        unique case (state)
            IDLE_STATE: begin
                if (ap_start) begin
                    state_next = LAUNCH;
                    count_next = '0;
                end
            end
            LAUNCH: state_next = CHECK;
            CHECK: begin
                if (actor_done) begin
                    if (actor_return == RET_EXEC) begin
                        state_next = LAUNCH;
                        count_next = count_inc;
                    end else if (actor_return == RET_TEST) begin
                        state_next = LAUNCH;
                    end else begin
                        state_next = SLEEP;
                        timer_next = SLEEP_LOAD;
                    end
                end
            end
            SLEEP: begin
                if (all_sleep) begin
                    state_next = SYNC_LAUNCH;
                end else if (MODE == 0) begin
                    if (timer == 16'd0) state_next = LAUNCH;
                    else timer_next = timer - 16'd1;
                end
            end
            SYNC_LAUNCH: state_next = SYNC_CHECK;
            SYNC_CHECK: begin
                if (actor_done) begin
                    if (actor_return == RET_EXEC) begin
                        state_next = SYNC_EXEC;
                        count_next = count_inc;
                    end else begin
                        state_next = SYNC_WAIT;
                    end
                end
            end
            SYNC_WAIT: begin
                if (all_sync) begin
                    if (all_sync_wait) begin
                        state_next = IDLE_STATE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = LAUNCH;
                    end
                end
            end
            SYNC_EXEC: begin
                if (all_sync) state_next = LAUNCH;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= IDLE_STATE;
            timer      <= 16'd0;
            exec_count <= '0;
            ap_done    <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            exec_count <= count_next;
            ap_done    <= done_next;
        end
    end

    assign ap_idle     = (state == IDLE_STATE);
    assign actor_start = (state == LAUNCH) || (state == SYNC_LAUNCH);
    assign sleep       = (state == SLEEP);
    assign sync_wait   = (state == SYNC_WAIT);
    assign sync_exec   = (state == SYNC_EXEC);

endmodule

// File: tb/tb_actor_sync_trigger.sv
// Directed bench: MODE 0 instance (a_*) and MODE 1 / 4-bit counter
// instance (b_*) sharing clock and reset.
module tb_actor_sync_trigger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic        a_start = 0, a_done_o, a_idle, a_astart, a_adone = 0;
    logic [31:0] a_ret = 0;
    logic        a_sleep, a_swait, a_sexec;
    logic        a_asleep = 0, a_async = 0, a_asyncw = 0;
    logic [31:0] a_count;

    logic        b_start = 0, b_done_o, b_idle, b_astart, b_adone = 0;
    logic [31:0] b_ret = 0;
    logic        b_sleep, b_swait, b_sexec;
    logic        b_asleep = 0, b_async = 0, b_asyncw = 0;
    logic [3:0]  b_count;

    int          a_pulses = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (a_astart) a_pulses++;

    actor_sync_trigger #(.MODE(0), .SLEEP_CYCLES(16), .COUNT_WIDTH(32)) dut_a (
        .ap_clk(clk), .ap_rst(rst), .ap_start(a_start), .ap_done(a_done_o),
        .ap_idle(a_idle), .actor_start(a_astart), .actor_done(a_adone),
        .actor_return(a_ret), .sleep(a_sleep), .sync_wait(a_swait),
        .sync_exec(a_sexec), .all_sleep(a_asleep), .all_sync(a_async),
        .all_sync_wait(a_asyncw), .exec_count(a_count)
    );

    actor_sync_trigger #(.MODE(1), .SLEEP_CYCLES(4), .COUNT_WIDTH(4)) dut_b (
        .ap_clk(clk), .ap_rst(rst), .ap_start(b_start), .ap_done(b_done_o),
        .ap_idle(b_idle), .actor_start(b_astart), .actor_done(b_adone),
        .actor_return(b_ret), .sleep(b_sleep), .sync_wait(b_swait),
        .sync_exec(b_sexec), .all_sleep(b_asleep), .all_sync(b_async),
        .all_sync_wait(b_asyncw), .exec_count(b_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic bad;
        #2;
        chk("rst_idle", a_idle, 1);
        chk("rst_count", a_count, 0);
        chk("rst_outs", {a_done_o, a_astart, a_sleep, a_swait, a_sexec}, 0);
        step();
        rst = 0;
        step();

        // Basic run: EXECUTED x3 then WAIT
        a_start = 1;
        step();
        a_start = 0;
        chk("start_lat", a_astart, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            a_adone = 1; a_ret = 3;
            step();
            a_adone = 0;
            chk("exec_relaunch", a_astart, 1);
        end
        chk("count3", a_count, 3);
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0;
        chk("pulses4", a_pulses, 4);
        chk("enter_sleep", a_sleep, 1);
        n = 1;
        while (a_sleep && n < 40) begin
            step();
            if (a_sleep) n++;
        end
        chk("sleep_len", n, 16);
        chk("sleep_relaunch", a_astart, 1);

        // Sync with progress elsewhere
        step();
        a_adone = 1; a_ret = 0;
        step();
        a_adone = 0;
        a_asleep = 1;
        step();
        a_asleep = 0;
        chk("sync_launch", {a_astart, a_sleep}, 2'b10);
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0;
        chk("sync_wait", a_swait, 1);
        a_async = 1; a_asyncw = 0;
        step();
        a_async = 0;
        chk("resync_launch", {a_astart, a_done_o}, 2'b10);
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0; a_asleep = 1;
        step();
        a_asleep = 0;
        step();
        a_adone = 1; a_ret = 3;
        step();
        a_adone = 0;
        chk("sync_exec", a_sexec, 1);
        chk("sync_exec_cnt", a_count, 4);
        a_async = 1;
        step();
        a_async = 0;
        chk("exec_to_launch", a_astart, 1);

        // Full quiescence
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0; a_asleep = 1;
        step();
        a_asleep = 0;
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0;
        a_async = 1; a_asyncw = 1;
        step();
        a_async = 0; a_asyncw = 0;
        chk("ap_done", {a_done_o, a_idle}, 2'b11);
        step();
        chk("done_pulse", {a_done_o, a_idle}, 2'b01);
        chk("count_hold", a_count, 4);

        // Timer expiry coincident with all_sleep
        a_start = 1;
        step();
        a_start = 0;
        chk("count_clr", a_count, 0);
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0;
        repeat (15) step();
        chk("sleep_t0", a_sleep, 1);
        a_asleep = 1;
        step();
        a_asleep = 0;
        chk("coinc_launch", a_astart, 1);
        step();
        a_adone = 1; a_ret = 1;
        step();
        a_adone = 0;
        chk("coinc_sync", {a_swait, a_sleep}, 2'b10);

        // ap_done coincident with ap_start
        a_async = 1; a_asyncw = 1;
        step();
        a_async = 0; a_asyncw = 0;
        a_start = 1;
        chk("coinc_done", a_done_o, 1);
        step();
        a_start = 0;
        chk("coinc_restart", {a_astart, a_done_o}, 2'b10);
        step();
        a_adone = 1; a_ret = 3;
        step();
        a_adone = 0;
        step();
        chk("pre_rst_cnt", a_count, 1);

        // Instance B: saturation, return 7, MODE 1 sleep
        b_start = 1;
        step();
        b_start = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            b_adone = 1; b_ret = 3;
            step();
            b_adone = 0;
        end
        chk("sat15", b_count, 15);
        step();
        b_adone = 1; b_ret = 7;
        step();
        b_adone = 0;
        chk("ret7_sleep", b_sleep, 1);
        bad = 0;
        repeat (120) begin
            step();
            if (!b_sleep || b_astart) bad = 1;
        end
        chk("mode1_hold", bad, 0);
        b_asleep = 1;
        step();
        b_asleep = 0;
        chk("mode1_sync", {b_astart, b_sleep}, 2'b10);

        // Async reset with A parked in CHECK, no clock edge
        #2;
        rst = 1;
        #1;
        chk("arst_idle", a_idle, 1);
        chk("arst_count", a_count, 0);
        chk("arst_b", {b_idle, b_count, b_astart}, 6'b100000);
        step();
        rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
